// File: rtl/vga_reg_panel.sv
// vga_reg_panel: renders NUM_CH frame-start snapshots of register channels as rows of bit cells,
// with per-channel change highlighting and a two-stage pixel pipeline. Optional macro VGA_REG_PANEL_BLINK_EN.
module vga_reg_panel #(
  parameter int          NUM_CH      = 6,
  parameter int          DATA_W      = 8,
  parameter logic [10:0] START_H     = 11'd50,
  parameter logic [10:0] START_V     = 11'd10,
  parameter int          ROW_PITCH   = 10,
  parameter int          BIT_W       = 8,
  parameter int          BIT_H       = 8,
  parameter int          HOLD_FRAMES = 30,
  parameter logic [2:0]  ON_COLOR    = 3'b100,
  parameter logic [2:0]  OFF_COLOR   = 3'b000,
  parameter logic [2:0]  GRID_COLOR  = 3'b010,
  parameter logic [2:0]  HL_COLOR    = 3'b110
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     frame_start,
  input  logic [10:0]              vga_h,
  input  logic [10:0]              vga_v,
  output logic [23:0]              pixel_out,
  output logic                     display_on
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int HW   = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);
  localparam int SH = int'(START_H);
  localparam int SV = int'(START_V);

  function automatic logic [23:0] expand_rgb(input logic [2:0] col);
    expand_rgb = {{8{col[2]}}, {8{col[1]}}, {8{col[0]}}};
  endfunction

  logic [DATA_W-1:0] shadow   [NUM_CH];
  logic [DATA_W-1:0] prev     [NUM_CH];
  logic [HW-1:0]     hold_cnt [NUM_CH];
  logic              primed;
  logic              chk_p1;
  logic [2:0]        hl_color;

  // Snapshot and change tracking; chk_p1 remembers whether the capture happened while primed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= 1'b0;
      chk_p1 <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c]   <= '0;
        prev[c]     <= '0;
        hold_cnt[c] <= '0;
      end
    end else begin
      chk_p1 <= frame_start & primed;
      if (frame_start) primed <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (frame_start) begin
          shadow[c] <= data_in[c*DATA_W +: DATA_W];
          prev[c]   <= shadow[c];
        end
        if (chk_p1 && (shadow[c] != prev[c]))
          hold_cnt[c] <= HOLD_INIT;
        else if (frame_start && (hold_cnt[c] != '0))
          hold_cnt[c] <= hold_cnt[c] - HW'(1);
      end
    end
  end

`ifdef VGA_REG_PANEL_BLINK_EN
  logic [3:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           frame_cnt <= 4'd0;
    else if (frame_start) frame_cnt <= frame_cnt + 4'd1;
  end

  assign hl_color = frame_cnt[3] ? ON_COLOR : HL_COLOR;
`else
  assign hl_color = HL_COLOR;
`endif

  int               h_i;
  int               v_i;
  logic             row_hit, col_hit, xgap, ygap;
  logic [CH_W-1:0]  ch_d;
  logic [BI_W-1:0]  bit_d;

  assign h_i = int'({21'd0, vga_h});
  assign v_i = int'({21'd0, vga_v});

  // Descending channel scan so the lowest overlapping row wins.
  always_comb begin
    row_hit = 1'b0;
    col_hit = 1'b0;
    xgap    = 1'b0;
    ygap    = 1'b0;
    ch_d    = '0;
    bit_d   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if ((v_i >= SV + c*ROW_PITCH) && (v_i < SV + c*ROW_PITCH + BIT_H)) begin
        row_hit = 1'b1;
        ch_d    = CH_W'(c);
        ygap    = (v_i == SV + c*ROW_PITCH + BIT_H - 1);
      end
    end
    for (int k = 0; k < DATA_W; k++) begin
      if ((h_i >= SH + k*BIT_W) && (h_i < SH + (k+1)*BIT_W)) begin
        col_hit = 1'b1;
        bit_d   = BI_W'(DATA_W - 1 - k);
        xgap    = (h_i == SH + (k+1)*BIT_W - 1);
      end
    end
  end

  // ---- stage 1: cell decode ----
  logic             vld_p1, gap_p1;
  logic [CH_W-1:0]  ch_p1;
  logic [BI_W-1:0]  bit_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      gap_p1 <= 1'b0;
      ch_p1  <= '0;
      bit_p1 <= '0;
    end else begin
      vld_p1 <= row_hit & col_hit;
      gap_p1 <= xgap | ygap;
      ch_p1  <= ch_d;
      bit_p1 <= bit_d;
    end
  end

  logic [DATA_W-1:0] word_sel;
  logic              hl_sel, bit_set;
  logic [2:0]        col_d;

  always_comb begin
    word_sel = '0;
    hl_sel   = 1'b0;
    bit_set  = 1'b0;
    col_d    = 3'b000;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_p1 == CH_W'(c)) begin
        word_sel = shadow[c];
        hl_sel   = (hold_cnt[c] != '0);
      end
    end
    for (int b = 0; b < DATA_W; b++) begin
      if (bit_p1 == BI_W'(b)) bit_set = word_sel[b];
    end
    if (!vld_p1)               col_d = 3'b000;
    else if (gap_p1)           col_d = GRID_COLOR;
    else if (bit_set && hl_sel) col_d = hl_color;
    else if (bit_set)          col_d = ON_COLOR;
    else                       col_d = OFF_COLOR;
  end

  // ---- stage 2: colour output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out  <= 24'h000000;
      display_on <= 1'b0;
    end else begin
      pixel_out  <= expand_rgb(col_d);
      display_on <= vld_p1;
    end
  end
endmodule
